// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction-fetch stage.
//   fetch_state_t : fetch FSM states (REQ, WAIT, HOLD, DRAIN)
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0) used for IF/ID bubbles
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,  // request presented to instruction memory
    WAIT  = 2'd1,  // request accepted, waiting for the response
    HOLD  = 2'd2,  // response captured while decode was stalled
    DRAIN = 2'd3   // outstanding response belongs to a squashed path
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, flush and hold controls.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   flush                  : squash contents (NOP, invalid); overrides everything
//   load                   : capture load_instr/load_pc/load_pc_plus4 as valid
//   stall                  : keep contents when not flushing or loading
//   load_instr/pc/pc_plus4 : incoming instruction, its PC and PC+4
//   instr, pc, pc_plus4    : registered IF/ID contents
//   valid                  : IF/ID holds a real instruction
// With neither load nor stall a bubble (NOP, invalid) is inserted.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  stall,
  input  logic [DATA_WIDTH-1:0] load_instr,
  input  logic [DATA_WIDTH-1:0] load_pc,
  input  logic [DATA_WIDTH-1:0] load_pc_plus4,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  valid
);

  localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_INSTR);

  // IF/ID state: flush beats load, load beats hold, otherwise bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= NOP_W;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      // PC fields are left alone: only the instruction and valid matter
      instr <= NOP_W;
      valid <= 1'b0;
    end else if (load) begin
      instr    <= load_instr;
      pc       <= load_pc;
      pc_plus4 <= load_pc_plus4;
      valid    <= 1'b1;
    end else if (stall) begin
      instr <= instr;
      valid <= valid;
    end else begin
      instr <= NOP_W;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction-fetch stage.
// Owns the PC, issues one outstanding fetch at a time over a valid/ready
// request channel, buffers a response that arrives while decode is stalled
// and feeds the IF/ID register.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   PCN, PCSrc                      : next PC from the next-PC mux, redirect strobe
//   StallD                          : decode stall from the hazard unit
//   PCF, PCPlus4F                   : current fetch PC and PC+4 (to next-PC mux)
//   imem_req_valid/ready, imem_addr : fetch request channel
//   imem_rsp_valid, imem_rsp_data   : fetch response (single-cycle pulse)
//   InstrD, PCD, PCPlus4D, ValidD   : IF/ID register outputs
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] PCN,
  input  logic                  PCSrc,
  input  logic                  StallD,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD
);

  localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_INSTR);
  localparam logic [DATA_WIDTH-1:0] FOUR  = DATA_WIDTH'(32'd4);

  fetch_state_t          state_r;
  fetch_state_t          state_nxt_s;
  logic [DATA_WIDTH-1:0] pc_r;
  logic [DATA_WIDTH-1:0] pc_nxt_s;
  logic [DATA_WIDTH-1:0] pc_plus4_s;
  logic [DATA_WIDTH-1:0] hold_buf_r;
  logic                  hold_wr_s;
  logic                  load_s;
  logic [DATA_WIDTH-1:0] load_instr_s;

  // Wraps modulo 2^DATA_WIDTH by construction.
  assign pc_plus4_s     = pc_r + FOUR;
  assign PCF            = pc_r;
  assign PCPlus4F       = pc_plus4_s;
  assign imem_addr      = pc_r;
  assign imem_req_valid = (state_r == REQ);

  // Next-state, next-PC and IF/ID load decode; redirect always has priority.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    load_s       = 1'b0;
    load_instr_s = imem_rsp_data;
    hold_wr_s    = 1'b0;
    case (state_r)
      REQ: begin
        if (PCSrc) begin
          pc_nxt_s = PCN;
          // an accepted request now fetches a dead path: its response must be drained
          if (imem_req_ready) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = REQ;
          end
        end else if (imem_req_ready) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (PCSrc) begin
          pc_nxt_s = PCN;
          if (imem_rsp_valid) begin
            state_nxt_s = REQ;
          end else begin
            state_nxt_s = DRAIN;
          end
        end else if (imem_rsp_valid) begin
          if (!StallD) begin
            load_s      = 1'b1;
            pc_nxt_s    = PCN;
            state_nxt_s = REQ;
          end else begin
            // PCF stays put so it still names the buffered instruction
            hold_wr_s   = 1'b1;
            state_nxt_s = HOLD;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      HOLD: begin
        if (PCSrc) begin
          pc_nxt_s    = PCN;
          state_nxt_s = REQ;
        end else if (!StallD) begin
          load_s       = 1'b1;
          load_instr_s = hold_buf_r;
          pc_nxt_s     = PCN;
          state_nxt_s  = REQ;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      DRAIN: begin
        if (PCSrc) begin
          pc_nxt_s = PCN;
          // a stale response in the same cycle still completes the drain
          if (imem_rsp_valid) begin
            state_nxt_s = REQ;
          end else begin
            state_nxt_s = DRAIN;
          end
        end else if (imem_rsp_valid) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = REQ;
        pc_nxt_s    = pc_r;
      end
    endcase
  end

  // FSM state and program counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= REQ;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // Hold buffer: captures a response that arrived while decode was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_buf_r <= NOP_W;
    end else if (hold_wr_s) begin
      hold_buf_r <= imem_rsp_data;
    end else begin
      hold_buf_r <= hold_buf_r;
    end
  end

  // PC fields come from PCF both for a direct load and for a HOLD load,
  // since PCF does not move while an instruction is buffered.
  if_id_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_if_id (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (PCSrc),
    .load         (load_s),
    .stall        (StallD),
    .load_instr   (load_instr_s),
    .load_pc      (pc_r),
    .load_pc_plus4(pc_plus4_s),
    .instr        (InstrD),
    .pc           (PCD),
    .pc_plus4     (PCPlus4D),
    .valid        (ValidD)
  );

endmodule
